// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the split of the log2(WIDTH) shift levels across pipeline stages.
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_LOGIC = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // Levels handled by every stage except possibly the last one.
  function automatic int unsigned levels_per_stage(input int unsigned shw,
                                                   input int unsigned stages);
    return (shw + stages - 1) / stages;
  endfunction

  // Lowest shift level owned by stage idx (clamped when stages run out of levels).
  function automatic int unsigned stage_first(input int unsigned shw,
                                              input int unsigned stages,
                                              input int unsigned idx);
    int unsigned f;
    f = idx * levels_per_stage(shw, stages);
    return (f > shw) ? shw : f;
  endfunction

  // Number of levels owned by stage idx; the last stage takes the remainder.
  function automatic int unsigned stage_count(input int unsigned shw,
                                              input int unsigned stages,
                                              input int unsigned idx);
    int unsigned f;
    int unsigned lps;
    f   = stage_first(shw, stages, idx);
    lps = levels_per_stage(shw, stages);
    return ((shw - f) < lps) ? (shw - f) : lps;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline slice of the barrel shifter: shift levels FIRST..FIRST+COUNT-1
// followed by an elastic valid/ready register. BARREL_FLAGS_EN adds carry/zero.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FIRST = 0,
  parameter int unsigned COUNT = 1,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready_c,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_right,
  input  mode_e            in_mode,
`ifdef BARREL_FLAGS_EN
  input  logic             in_carry,
  output logic             out_carry,
  output logic             out_zero,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic             out_right,
  output mode_e            out_mode
);

  logic [WIDTH-1:0] nxt_data;
  logic [WIDTH-1:0] fill;
  logic [SHW-1:0]   sh_bits;
  int unsigned      amt;
`ifdef BARREL_FLAGS_EN
  logic [WIDTH-1:0] tap;
  logic             nxt_carry;
`endif

  assign in_ready_c = !out_valid || out_ready;

  // Shift levels owned by this stage; the last bit pushed out becomes the carry.
  always_comb begin
    nxt_data = in_data;
    fill     = '0;
    sh_bits  = '0;
    amt      = 0;
`ifdef BARREL_FLAGS_EN
    tap       = '0;
    nxt_carry = in_carry;
`endif
    for (int j = 0; j < int'(COUNT); j++) begin
      sh_bits = in_shift >> (FIRST + j);
      amt     = 1 << (FIRST + j);
      if (sh_bits[0]) begin
        if (in_mode == MODE_ROT) begin
          nxt_data = in_right ? ((nxt_data >> amt) | (nxt_data << (WIDTH - amt)))
                              : ((nxt_data << amt) | (nxt_data >> (WIDTH - amt)));
        end else if (in_right) begin
`ifdef BARREL_FLAGS_EN
          tap       = nxt_data >> (amt - 1);
          nxt_carry = tap[0];
`endif
          fill     = (in_mode == MODE_ARITH && nxt_data[WIDTH-1]) ? '1 : '0;
          nxt_data = (nxt_data >> amt) | (fill << (WIDTH - amt));
        end else begin
`ifdef BARREL_FLAGS_EN
          tap       = nxt_data >> (WIDTH - amt);
          nxt_carry = tap[0];
`endif
          nxt_data = nxt_data << amt;
        end
      end
    end
  end

  // Elastic register slice; payload only moves with a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_right <= 1'b0;
      out_mode  <= MODE_LOGIC;
`ifdef BARREL_FLAGS_EN
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= nxt_data;
        out_shift <= in_shift;
        out_right <= in_right;
        out_mode  <= in_mode;
`ifdef BARREL_FLAGS_EN
        out_carry <= nxt_carry;
        out_zero  <= (nxt_data == '0);
`endif
      end
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined logical/arithmetic/rotate barrel shifter with valid/ready flow control.
// Optional macro BARREL_FLAGS_EN adds registered out_zero and out_carry outputs.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_right,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARREL_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_carry
`endif
);

  logic             valid_s [STAGES+1];
  logic             ready_s [STAGES+1];
  logic [WIDTH-1:0] data_s  [STAGES+1];
  logic [SHW-1:0]   shift_s [STAGES+1];
  logic             right_s [STAGES+1];
  mode_e            mode_s  [STAGES+1];
`ifdef BARREL_FLAGS_EN
  logic             carry_s [STAGES+1];
  logic             zero_s  [1:STAGES];

  assign carry_s[0] = 1'b0;
  assign out_carry  = carry_s[STAGES];
  assign out_zero   = zero_s[STAGES];
`else
  // Flag pipeline is not built; data path is identical.
`endif

  assign valid_s[0]      = in_valid;
  assign data_s[0]       = in_data;
  assign shift_s[0]      = in_shift;
  assign right_s[0]      = in_right;
  assign mode_s[0]       = mode_e'(in_mode);
  assign ready_s[STAGES] = out_ready;
  assign in_ready        = ready_s[0];
  assign out_valid       = valid_s[STAGES];
  assign out_data        = data_s[STAGES];

  // Stage i owns a contiguous run of levels, lowest levels first.
  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .FIRST (stage_first(SHW, STAGES, i)),
      .COUNT (stage_count(SHW, STAGES, i))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (valid_s[i]),
      .in_ready_c (ready_s[i]),
      .in_data    (data_s[i]),
      .in_shift   (shift_s[i]),
      .in_right   (right_s[i]),
      .in_mode    (mode_s[i]),
`ifdef BARREL_FLAGS_EN
      .in_carry   (carry_s[i]),
      .out_carry  (carry_s[i+1]),
      .out_zero   (zero_s[i+1]),
`endif
      .out_valid  (valid_s[i+1]),
      .out_ready  (ready_s[i+1]),
      .out_data   (data_s[i+1]),
      .out_shift  (shift_s[i+1]),
      .out_right  (right_s[i+1]),
      .out_mode   (mode_s[i+1])
    );
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed self-checking bench for barrel_shift_pipe (WIDTH=32, STAGES=2).
module tb_barrel_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shift;
  logic        in_right;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef BARREL_FLAGS_EN
  logic        out_zero;
  logic        out_carry;
`endif

  int errors = 0;
  int checks = 0;

  barrel_shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_right  (in_right),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARREL_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference: output bit i takes source bit i+s (right) or i-s (left).
  function automatic logic [31:0] ref_model(input logic [31:0] d, input int s,
                                            input logic r, input logic [1:0] m);
    logic [31:0] res;
    int src;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      src = r ? i + s : i - s;
      if (m == 2'b10)
        res[5'(i)] = d[5'((src + 32) % 32)];
      else if (src >= 0 && src < 32)
        res[5'(i)] = d[5'(src)];
      else
        res[5'(i)] = (r && m == 2'b01) ? d[31] : 1'b0;
    end
    return res;
  endfunction

  // Present one beat with out_ready high; returns result and edges until out_valid.
  task automatic single_beat(input logic [31:0] d, input logic [4:0] s, input logic r,
                             input logic [1:0] m, output logic [31:0] res, output int lat);
    int w;
    @(negedge clk);
    in_data = d; in_shift = s; in_right = r; in_mode = m;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    res = '0;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (out_valid) res = out_data;
    else lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shift = '0; in_right = 1'b0; in_mode = 2'b00;
    @(negedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_vectors;
    logic [31:0] vd [13] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000,
                             32'h80000000, 32'h80000000, 32'h0000000F, 32'hC0000001,
                             32'h40000000, 32'h80000001, 32'h87654321, 32'h87654321,
                             32'h87654321};
    logic [4:0]  vs [13] = '{5'd1, 5'd27, 5'd27, 5'd3, 5'd3, 5'd3, 5'd4, 5'd1,
                             5'd4, 5'd0, 5'd31, 5'd31, 5'd31};
    logic        vr [13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  vm [13] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01,
                             2'b01, 2'b01, 2'b00, 2'b01, 2'b10};
    logic [31:0] ve [13] = '{32'h00000002, 32'h00000000, 32'h00000020, 32'hF0000000,
                             32'h10000000, 32'h00000004, 32'h000000F0, 32'h80000002,
                             32'h04000000, 32'h80000001, 32'h00000001, 32'hFFFFFFFF,
                             32'hC3B2A190};
    logic [31:0] res;
    int lat;
    for (int k = 0; k < 13; k++) begin
      single_beat(vd[k], vs[k], vr[k], vm[k], res, lat);
      checks++;
      if (res !== ve[k]) begin
        errors++;
        $display("FAIL vector%0d_data got=%h want=%h", k, res, ve[k]);
      end
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL vector%0d_latency got=%0d want=2", k, lat);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] got [$];
    logic ra, rb, c_fire;
    int iters;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000011; in_shift = 5'd4; in_right = 1'b0; in_mode = 2'b00;
    #1; ra = in_ready;
    @(negedge clk);
    in_data = 32'h00000022; in_shift = 5'd1; in_right = 1'b1; in_mode = 2'b00;
    #1; rb = in_ready;
    @(negedge clk);
    in_data = 32'hF0000000; in_shift = 5'd4; in_right = 1'b1; in_mode = 2'b10;
    #1;
    checks++;
    if (ra !== 1'b1 || rb !== 1'b1) begin
      errors++; $display("FAIL stall_accept_ab got=%b%b want=11", ra, rb);
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00000110) begin
        errors++;
        $display("FAIL stall_hold%0d got ready=%b valid=%b data=%h want ready=0 valid=1 data=00000110",
                 h, in_ready, out_valid, out_data);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    iters = 0;
    while (got.size() < 3 && iters < 10) begin
      if (out_valid && out_ready) got.push_back(out_data);
      c_fire = in_valid && in_ready;
      iters++;
      @(negedge clk);
      if (c_fire) in_valid = 1'b0;
      #1;
    end
    checks++;
    if (got.size() != 3 || iters != 3) begin
      errors++; $display("FAIL stall_drain_count got=%0d in %0d cycles want=3 in 3", got.size(), iters);
    end else begin
      checks++;
      if (got[0] !== 32'h00000110 || got[1] !== 32'h00000011 || got[2] !== 32'h0F000000) begin
        errors++;
        $display("FAIL stall_order got=%h,%h,%h want=00000110,00000011,0F000000", got[0], got[1], got[2]);
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b want=0", out_valid); end
  endtask

  task automatic test_stream;
    logic [31:0] sd [16];
    logic [4:0]  ss [16];
    logic        sr [16];
    logic [1:0]  sm [16];
    logic [31:0] se [16];
    int in_idx, out_idx, cyc;
    logic tog;
    for (int i = 0; i < 16; i++) begin
      sd[i] = 32'h9E3779B9 ^ (32'(i) * 32'h01010101) ^ (32'h80000000 >> i);
      ss[i] = 5'((i * 7 + 3) % 32);
      sr[i] = (i % 2) == 1;
      sm[i] = 2'(i % 4);
      se[i] = ref_model(sd[i], int'(ss[i]), sr[i], sm[i]);
    end
    in_idx = 0; out_idx = 0; cyc = 0; tog = 1'b0;
    while (out_idx < 16 && cyc < 200) begin
      @(negedge clk);
      in_valid = (in_idx < 16);
      if (in_idx < 16) begin
        in_data = sd[in_idx]; in_shift = ss[in_idx]; in_right = sr[in_idx]; in_mode = sm[in_idx];
      end
      out_ready = tog;
      tog = ~tog;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== se[out_idx]) begin
          errors++; $display("FAIL stream%0d got=%h want=%h", out_idx, out_data, se[out_idx]);
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      cyc++;
    end
    checks++;
    if (out_idx != 16) begin errors++; $display("FAIL stream_complete got=%0d want=16", out_idx); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat, stale;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678; in_shift = 5'd8; in_right = 1'b0; in_mode = 2'b00;
    @(negedge clk);
    in_data = 32'hDEADBEEF; in_shift = 5'd4; in_right = 1'b1; in_mode = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h34567800) begin
      errors++; $display("FAIL midrst_inflight got valid=%b data=%h want valid=1 data=34567800", out_valid, out_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL midrst_async got valid=%b data=%h want valid=0 data=00000000", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midrst_stale got=%0d want=0", stale); end
    single_beat(32'hA5A5A5A5, 5'd0, 1'b0, 2'b10, res, lat);
    checks++;
    if (res !== 32'hA5A5A5A5 || lat != 2) begin
      errors++; $display("FAIL midrst_next got=%h lat=%0d want=A5A5A5A5 lat=2", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
